// File: rtl/fetch_issue_unit.sv
// rtl/fetch_issue_unit.sv - buffers instruction-cache blocks and issues one instruction per cycle to decode
// Bit numbering of block slots and of the 32-bit address mask is POWER style: bit 0 is the MSB.
module fetch_issue_unit #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int blockInstCount          = 4,
  parameter int queueDepth              = 2
) (
  input  logic                                       clock_i,
  input  logic                                       reset_i,
  input  logic                                       flush_i,
  input  logic                                       blockValid_i,
  output logic                                       blockReady_o,
  input  logic [blockInstCount*instructionWidth-1:0] block_i,
  input  logic [addressWidth-1:0]                    blockAddress_i,
  input  logic [$clog2(blockInstCount)-1:0]          blockStartSlot_i,
  input  logic                                       blockIs64Bit_i,
  input  logic [PidSize-1:0]                         blockPid_i,
  input  logic [TidSize-1:0]                         blockTid_i,
  input  logic                                       stall_i,
  output logic                                       enable_o,
  output logic [instructionWidth-1:0]                instruction_o,
  output logic [addressWidth-1:0]                    instructionAddress_o,
  output logic                                       is64Bit_o,
  output logic [PidSize-1:0]                         instructionPid_o,
  output logic [TidSize-1:0]                         instructionTid_o,
  output logic [instructionCounterWidth-1:0]         instructionMajId_o
);
  localparam int SlotW  = $clog2(blockInstCount);
  localparam int PtrW   = (queueDepth > 1) ? $clog2(queueDepth) : 1;
  localparam int CntW   = $clog2(queueDepth + 1);
  localparam int BlockW = blockInstCount * instructionWidth;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(blockInstCount - 1);
  localparam logic [addressWidth-1:0] OffMask = addressWidth'(blockInstCount * 4 - 1);
  localparam logic [addressWidth-1:0] Low32 = addressWidth'(64'hFFFF_FFFF);

  logic [BlockW-1:0]       blk_mem_q   [queueDepth];
  logic [addressWidth-1:0] addr_mem_q  [queueDepth];
  logic [SlotW-1:0]        start_mem_q [queueDepth];
  logic                    m64_mem_q   [queueDepth];
  logic [PidSize-1:0]      pid_mem_q   [queueDepth];
  logic [TidSize-1:0]      tid_mem_q   [queueDepth];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic en_q, en_d, m64_q, m64_d;
  logic [instructionWidth-1:0] instr_q, instr_d;
  logic [addressWidth-1:0] addr_q, addr_d, issue_addr;
  logic [PidSize-1:0] pid_q, pid_d;
  logic [TidSize-1:0] tid_q, tid_d;
  logic [instructionCounterWidth-1:0] maj_q, maj_d, ctr_q, ctr_d;
  logic [BlockW-1:0] head_blk;
  logic push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(queueDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // No pop credit: a full queue refuses a block even on a cycle that pops.
  assign blockReady_o = (count_q < CntW'(queueDepth)) && reset_i;
  assign push         = blockValid_i && blockReady_o && !flush_i;
  assign head_blk     = blk_mem_q[head_q];

  always_comb begin
    issue_addr = (addr_mem_q[head_q] & ~OffMask) + addressWidth'({slot_q, 2'b00});
    if (!m64_mem_q[head_q]) issue_addr = issue_addr & Low32;
  end

  always_comb begin
    head_d = head_q; tail_d = tail_q; count_d = count_q; slot_d = slot_q;
    en_d = en_q; instr_d = instr_q; addr_d = addr_q; m64_d = m64_q;
    pid_d = pid_q; tid_d = tid_q; maj_d = maj_q; ctr_d = ctr_q;
    pop = 1'b0;
    if (flush_i) begin
      head_d = '0; tail_d = '0; count_d = '0; slot_d = '0; en_d = 1'b0;
    end else begin
      if (!en_q || !stall_i) begin
        if (count_q != '0) begin
          en_d    = 1'b1;
          instr_d = head_blk[(blockInstCount - 1 - int'(slot_q)) * instructionWidth +: instructionWidth];
          addr_d  = issue_addr;
          m64_d   = m64_mem_q[head_q];
          pid_d   = pid_mem_q[head_q];
          tid_d   = tid_mem_q[head_q];
          maj_d   = ctr_q;
          ctr_d   = ctr_q + 1'b1;
          pop     = (slot_q == LastSlot);
          if (!pop) slot_d = slot_q + 1'b1;
        end else begin
          en_d = 1'b0;
        end
      end
      if (push) tail_d = ptr_inc(tail_q);
      // The slot pointer follows whichever entry becomes the new head.
      if (pop) begin
        head_d = ptr_inc(head_q);
        if (count_q > CntW'(1)) slot_d = start_mem_q[ptr_inc(head_q)];
        else if (push)          slot_d = blockStartSlot_i;
        else                    slot_d = '0;
      end else if (push && count_q == '0) begin
        slot_d = blockStartSlot_i;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) begin
      blk_mem_q[tail_q]   <= block_i;
      addr_mem_q[tail_q]  <= blockAddress_i;
      start_mem_q[tail_q] <= blockStartSlot_i;
      m64_mem_q[tail_q]   <= blockIs64Bit_i;
      pid_mem_q[tail_q]   <= blockPid_i;
      tid_mem_q[tail_q]   <= blockTid_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q <= '0; tail_q <= '0; count_q <= '0; slot_q <= '0;
      en_q <= 1'b0; instr_q <= '0; addr_q <= '0; m64_q <= 1'b0;
      pid_q <= '0; tid_q <= '0; maj_q <= '0; ctr_q <= '0;
    end else begin
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d; slot_q <= slot_d;
      en_q <= en_d; instr_q <= instr_d; addr_q <= addr_d; m64_q <= m64_d;
      pid_q <= pid_d; tid_q <= tid_d; maj_q <= maj_d; ctr_q <= ctr_d;
    end
  end

  assign enable_o             = en_q;
  assign instruction_o        = instr_q;
  assign instructionAddress_o = addr_q;
  assign is64Bit_o            = m64_q;
  assign instructionPid_o     = pid_q;
  assign instructionTid_o     = tid_q;
  assign instructionMajId_o   = maj_q;
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb/tb_fetch_issue_unit.sv - directed vectors, corner sequences and random run against a block-queue model
module tb_fetch_issue_unit;
  logic clock_i = 1'b0, reset_i = 1'b0, flush_i = 1'b0, blockValid_i = 1'b0;
  logic blockReady_o, blockIs64Bit_i = 1'b0, stall_i = 1'b0;
  logic [127:0] block_i = '0;
  logic [63:0] blockAddress_i = '0;
  logic [1:0] blockStartSlot_i = '0;
  logic [19:0] blockPid_i = '0;
  logic [15:0] blockTid_i = '0;
  logic enable_o, is64Bit_o;
  logic [31:0] instruction_o;
  logic [63:0] instructionAddress_o, instructionMajId_o;
  logic [19:0] instructionPid_o;
  logic [15:0] instructionTid_o;

  localparam logic [31:0] K = 32'h5A5A_0000;

  fetch_issue_unit dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
    .blockValid_i(blockValid_i), .blockReady_o(blockReady_o), .block_i(block_i),
    .blockAddress_i(blockAddress_i), .blockStartSlot_i(blockStartSlot_i),
    .blockIs64Bit_i(blockIs64Bit_i), .blockPid_i(blockPid_i), .blockTid_i(blockTid_i),
    .stall_i(stall_i), .enable_o(enable_o), .instruction_o(instruction_o),
    .instructionAddress_o(instructionAddress_o), .is64Bit_o(is64Bit_o),
    .instructionPid_o(instructionPid_o), .instructionTid_o(instructionTid_o),
    .instructionMajId_o(instructionMajId_o)
  );

  always #5 clock_i = ~clock_i;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Directed blocks: each word is derived from its own instruction address.
  function automatic logic [127:0] mkblk(input logic [63:0] a);
    logic [127:0] w;
    logic [63:0] ia;
    for (int k = 0; k < 4; k++) begin
      ia = (a & ~64'hF) + 64'(4 * k);
      w[127 - 32 * k -: 32] = ia[31:0] ^ K;
    end
    return w;
  endfunction

  task automatic set_blk(input logic v, input logic [63:0] a, input logic [1:0] s, input logic m);
    blockValid_i = v; blockAddress_i = a; blockStartSlot_i = s; blockIs64Bit_i = m;
    block_i = mkblk(a); blockPid_i = a[31:12]; blockTid_i = a[15:0];
  endtask

  // Reference model: FIFO of whole blocks, each carrying its next slot to issue.
  typedef struct { logic [127:0] w; logic [63:0] a; int slot; logic m; logic [19:0] p; logic [15:0] t; } mblk_t;
  mblk_t mq[$];
  bit model_on = 0;
  logic m_en, m_m64;
  logic [31:0] m_instr;
  logic [63:0] m_addr, m_maj, m_ctr;
  logic [19:0] m_pid;
  logic [15:0] m_tid;

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_m64 = 0; m_instr = 0; m_addr = 0; m_maj = 0; m_ctr = 0; m_pid = 0; m_tid = 0;
  endtask

  task automatic model_step();
    mblk_t h;
    bit rdy;
    rdy = (mq.size() < 2);
    if (flush_i) begin
      mq.delete();
      m_en = 0;
    end else begin
      if (!m_en || !stall_i) begin
        if (mq.size() > 0) begin
          h = mq[0];
          m_en = 1;
          m_instr = h.w[127 - 32 * h.slot -: 32];
          m_addr = (h.a / 16) * 16 + 64'(4 * h.slot);
          if (!h.m) m_addr = m_addr % 64'h1_0000_0000;
          m_m64 = h.m; m_pid = h.p; m_tid = h.t;
          m_maj = m_ctr; m_ctr = m_ctr + 1;
          h.slot++;
          if (h.slot == 4) void'(mq.pop_front());
          else mq[0] = h;
        end else begin
          m_en = 0;
        end
      end
      if (blockValid_i && rdy)
        mq.push_back('{block_i, blockAddress_i, int'(blockStartSlot_i), blockIs64Bit_i, blockPid_i, blockTid_i});
    end
  endtask

  task automatic model_check();
    chk("rnd_ready", blockReady_o, mq.size() < 2);
    chk("rnd_en", enable_o, m_en);
    chk("rnd_instr", instruction_o, m_instr);
    chk("rnd_addr", instructionAddress_o, m_addr);
    chk("rnd_64", is64Bit_o, m_m64);
    chk("rnd_pid", instructionPid_o, m_pid);
    chk("rnd_tid", instructionTid_o, m_tid);
    chk("rnd_maj", instructionMajId_o, m_maj);
  endtask

  task automatic tick();
    if (model_on) model_step();
    @(posedge clock_i);
    #1;
    if (model_on) model_check();
  endtask

  task automatic exp_issue(input string nm, input logic [63:0] a, input logic [63:0] m);
    chk({nm, "_en"}, enable_o, 1);
    chk({nm, "_addr"}, instructionAddress_o, a);
    chk({nm, "_maj"}, instructionMajId_o, m);
    chk({nm, "_instr"}, instruction_o, a[31:0] ^ K);
  endtask

  typedef struct {
    logic v; logic [63:0] a; logic [1:0] s;
    logic e_en; logic [63:0] e_addr; logic [63:0] e_maj; logic e_rdy;
  } vec_t;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b1, 64'h1000, 2'd0, 1'b0, 64'h0,    64'd0, 1'b1};
    vecs[1]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h1000, 64'd0, 1'b1};
    vecs[2]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h1004, 64'd1, 1'b1};
    vecs[3]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h1008, 64'd2, 1'b1};
    vecs[4]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h100C, 64'd3, 1'b1};
    vecs[5]  = '{1'b0, 64'h0,    2'd0, 1'b0, 64'h0,    64'd0, 1'b1};
    vecs[6]  = '{1'b1, 64'h2000, 2'd2, 1'b0, 64'h0,    64'd0, 1'b1};
    vecs[7]  = '{1'b1, 64'h3000, 2'd0, 1'b1, 64'h2008, 64'd4, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h200C, 64'd5, 1'b1};
    vecs[9]  = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h3000, 64'd6, 1'b1};
    vecs[10] = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h3004, 64'd7, 1'b1};
    vecs[11] = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h3008, 64'd8, 1'b1};
    vecs[12] = '{1'b0, 64'h0,    2'd0, 1'b1, 64'h300C, 64'd9, 1'b1};
    vecs[13] = '{1'b0, 64'h0,    2'd0, 1'b0, 64'h0,    64'd0, 1'b1};

    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_ready", blockReady_o, 0);
    chk("rst_en", enable_o, 0);
    chk("rst_maj", instructionMajId_o, 0);
    reset_i = 1'b1;
    tick();
    chk("post_rst_ready", blockReady_o, 1);
    chk("post_rst_en", enable_o, 0);

    for (int i = 0; i < 14; i++) begin
      set_blk(vecs[i].v, vecs[i].a, vecs[i].s, 1'b1);
      tick();
      chk($sformatf("vec%0d_rdy", i), blockReady_o, vecs[i].e_rdy);
      if (vecs[i].e_en) exp_issue($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_maj);
      else chk($sformatf("vec%0d_en", i), enable_o, 0);
    end

    // Stall while the second instruction is presented.
    set_blk(1, 64'h4000, 0, 1); tick();
    set_blk(0, 0, 0, 1); tick(); exp_issue("stl0", 64'h4000, 10);
    tick(); exp_issue("stl1", 64'h4004, 11);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); exp_issue("stl_hold", 64'h4004, 11); end
    stall_i = 1'b0;
    tick(); exp_issue("stl2", 64'h4008, 12);
    tick(); exp_issue("stl3", 64'h400C, 13);
    tick(); chk("stl_end_en", enable_o, 0);

    // Backpressure: third block refused until the head pops.
    set_blk(1, 64'h5000, 0, 1); tick();
    stall_i = 1'b1; set_blk(1, 64'h6000, 0, 1); tick();
    exp_issue("bp0", 64'h5000, 14);
    chk("bp_full_rdy", blockReady_o, 0);
    set_blk(1, 64'h7000, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick(); exp_issue("bp_hold", 64'h5000, 14); chk("bp_hold_rdy", blockReady_o, 0);
    end
    stall_i = 1'b0;
    tick(); exp_issue("bp1", 64'h5004, 15); chk("bp1_rdy", blockReady_o, 0);
    tick(); exp_issue("bp2", 64'h5008, 16);
    tick(); exp_issue("bp3", 64'h500C, 17); chk("bp3_rdy", blockReady_o, 1);
    tick(); exp_issue("bp4", 64'h6000, 18); chk("bp4_rdy", blockReady_o, 0);
    set_blk(0, 0, 0, 1);
    for (int k = 1; k < 8; k++) begin
      tick();
      exp_issue($sformatf("bp_drain%0d", k), (k < 4) ? 64'h6000 + 64'(4 * k) : 64'h7000 + 64'(4 * (k - 4)), 64'(18 + k));
    end
    tick(); chk("bp_end_en", enable_o, 0);

    // Flush mid-block, together with stall and an incoming block that must be dropped.
    set_blk(1, 64'h8000, 0, 1); tick();
    set_blk(0, 0, 0, 1); tick(); exp_issue("fl0", 64'h8000, 26);
    tick(); exp_issue("fl1", 64'h8004, 27);
    flush_i = 1'b1; stall_i = 1'b1; set_blk(1, 64'hB000, 0, 1); tick();
    flush_i = 1'b0; stall_i = 1'b0; set_blk(0, 0, 0, 1);
    chk("fl_en", enable_o, 0);
    chk("fl_rdy", blockReady_o, 1);
    chk("fl_addr_hold", instructionAddress_o, 64'h8004);
    chk("fl_maj_hold", instructionMajId_o, 27);
    tick(); chk("fl_empty_en", enable_o, 0);
    set_blk(1, 64'h9000, 1, 1); tick();
    set_blk(0, 0, 0, 1); tick(); exp_issue("fl_next", 64'h9004, 28);
    tick(); exp_issue("fl_next1", 64'h9008, 29);
    tick(); exp_issue("fl_next2", 64'h900C, 30);
    tick(); chk("fl_next_end", enable_o, 0);

    // Start slot at the last position issues exactly one instruction.
    set_blk(1, 64'hA000, 3, 1); tick();
    set_blk(0, 0, 0, 1); tick(); exp_issue("last_slot", 64'hA00C, 31);
    tick(); chk("last_slot_end", enable_o, 0);

    // 32-bit mode clears the upper address word.
    set_blk(1, 64'h1_0000_1000, 0, 0); tick();
    set_blk(0, 0, 0, 0); tick(); exp_issue("m32", 64'h1000, 32);
    chk("m32_mode", is64Bit_o, 0);
    tick(); exp_issue("m32b", 64'h1004, 33);

    // Asynchronous reset between clock edges.
    #2 reset_i = 1'b0;
    #1;
    chk("arst_en", enable_o, 0);
    chk("arst_addr", instructionAddress_o, 0);
    chk("arst_maj", instructionMajId_o, 0);
    chk("arst_instr", instruction_o, 0);
    chk("arst_rdy", blockReady_o, 0);
    @(negedge clock_i);
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;

    model_reset();
    model_on = 1;
    for (int i = 0; i < 2000; i++) begin
      blockValid_i = 1'($urandom_range(0, 1));
      blockAddress_i = {$urandom, $urandom};
      blockStartSlot_i = 2'($urandom_range(0, 3));
      blockIs64Bit_i = 1'($urandom_range(0, 1));
      block_i = {$urandom, $urandom, $urandom, $urandom};
      blockPid_i = 20'($urandom);
      blockTid_i = 16'($urandom);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 31) == 0);
      tick();
    end
    model_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
